key_entry_debounce: RTL

- Input-side partner of the 4-digit seven-segment display driver; produces that driver's `key` bit and its one-cycle `pulse_p` shift strobe.
- Takes two raw, bouncy, active-low push-buttons: BTN0 enters a 0, BTN1 enters a 1.
- Synchronises and debounces them, then emits exactly one qualified key event per clean press/release cycle.
- Sits between board button pins and the display driver, on the same 50 MHz clock.

---
 rtl/key_entry_debounce.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/key_entry_debounce.sv
// Two-button key entry: synchronise and debounce active-low buttons, then emit
// one key/pulse_p event per clean press/release cycle for the display driver.

module key_entry_debounce_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic p
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      p    <= 1'b0;
    end else begin
      meta <= ~raw_n;
      p    <= meta;
    end
  end
endmodule

module key_entry_debounce #(
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0_n,
  input  logic btn1_n,
  output logic key,
  output logic pulse_p,
  output logic busy
);
  localparam int NUM_BTN = 2;
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  DB_LAST   = 8'(STABLE_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  logic [NUM_BTN-1:0] raw_n;
  logic [NUM_BTN-1:0] p;
  logic [15:0]        tick_cnt;
  logic               tick;
  state_t             state, state_nxt;
  logic [7:0]         db_cnt, db_cnt_nxt;
  logic [1:0]         pattern, pattern_nxt;
  logic               cand, cand_nxt;
  logic               key_nxt, pulse_nxt;

  assign raw_n = {btn1_n, btn0_n};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_sync
      key_entry_debounce_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .raw_n (raw_n[g]),
        .p     (p[g])
      );
    end
  endgenerate

  // Free-running tick base; FSM activity never disturbs its phase.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick ? '0 : tick_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      db_cnt  <= '0;
      pattern <= '0;
      cand    <= 1'b0;
      key     <= 1'b0;
      pulse_p <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      db_cnt  <= db_cnt_nxt;
      pattern <= pattern_nxt;
      cand    <= cand_nxt;
      key     <= key_nxt;
      pulse_p <= pulse_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    pattern_nxt = pattern;
    cand_nxt    = cand;
    key_nxt     = key;
    pulse_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (p[0] ^ p[1]) begin
          cand_nxt    = p[1];
          pattern_nxt = p;
          db_cnt_nxt  = '0;
          state_nxt   = PRESS_DB;
        end else if (&p) begin
          // Chord: wait out the release without producing an event.
          db_cnt_nxt = '0;
          state_nxt  = REL_DB;
        end
      end
      PRESS_DB: begin
        if (p != pattern) begin
          db_cnt_nxt = '0;
          state_nxt  = IDLE;
        end else if (tick) begin
          if (db_cnt == DB_LAST) begin
            key_nxt   = cand;
            pulse_nxt = 1'b1;
            state_nxt = HELD;
          end else begin
            db_cnt_nxt = db_cnt + 8'd1;
          end
        end
      end
      HELD: begin
        if (p == 2'b00) begin
          db_cnt_nxt = '0;
          state_nxt  = REL_DB;
        end
      end
      REL_DB: begin
        if (|p) begin
          db_cnt_nxt = '0;
        end else if (tick) begin
          if (db_cnt == DB_LAST) state_nxt = IDLE;
          else                   db_cnt_nxt = db_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
